// File: rtl/mii_rx_frame_if.sv
// MII receive pins on one side and the byte stream/frame counters on the other.
// slave = the framer, master = whoever drives the PHY pins and observes the stream.
interface mii_rx_frame_if;
  logic        mii_rxdv;
  logic [3:0]  mii_rxd;
  logic        mii_rxer;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  modport slave (
    input  mii_rxdv, mii_rxd, mii_rxer,
    output out_data, out_valid, out_sof, out_eof, out_err, good_count, bad_count
  );

  modport master (
    output mii_rxdv, mii_rxd, mii_rxer,
    input  out_data, out_valid, out_sof, out_eof, out_err, good_count, bad_count
  );
endinterface

// File: rtl/mii_rx_frame.sv
// MII receive framer: strips preamble/SFD, packs nibbles (low first) into bytes,
// checks FCS/length/alignment/PHY errors and keeps good/bad frame counters.
module mii_rx_frame #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CHECK_CRC = 1
) (
  input logic           clk,
  input logic           rst_n,
  mii_rx_frame_if.slave bus
);

  // Stream handshake: out_valid marks a byte in the cycle it is presented; there is
  // no ready, the consumer must accept every valid byte. sof/eof/err qualify with valid.

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);
  localparam logic [10:0] CNT_SAT     = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic        rxdv_r;
  logic [3:0]  rxd_r;
  logic        rxer_r;
  logic        in_ok;
  logic        synced;

  logic        phase;
  logic [3:0]  lo_nib;
  logic [7:0]  hold;
  logic        hold_valid;
  logic        first;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic        rxer_seen;

  logic        start_data;
  logic        byte_done;
  logic        close_frame;
  logic        drop_end;
  logic        frame_bad;
  logic [7:0]  new_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Single input register stage; in_ok/synced make sure a frame already running
  // when reset is released is dropped instead of being half-parsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxdv_r <= 1'b0;
      rxd_r  <= 4'd0;
      rxer_r <= 1'b0;
      in_ok  <= 1'b0;
      synced <= 1'b0;
    end else begin
      rxdv_r <= bus.mii_rxdv;
      rxd_r  <= bus.mii_rxd;
      rxer_r <= bus.mii_rxer;
      in_ok  <= 1'b1;
      if (in_ok && !rxdv_r) synced <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_data  = 1'b0;
    byte_done   = 1'b0;
    close_frame = 1'b0;
    drop_end    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxdv_r) state_nxt = (synced && rxd_r == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rxdv_r) begin
          state_nxt = IDLE;
        end else if (rxd_r == 4'hD) begin
          state_nxt  = DATA;
          start_data = 1'b1;
        end else if (rxd_r != 4'h5) begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (!rxdv_r) begin
          state_nxt   = IDLE;
          close_frame = 1'b1;
        end else if (phase) begin
          byte_done = 1'b1;
        end
      end
      DROP: begin
        if (!rxdv_r) begin
          state_nxt = IDLE;
          drop_end  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign new_byte  = {rxd_r, lo_nib};
  // phase=1 at close means a dangling low nibble (dribble bits).
  assign frame_bad = ((CHECK_CRC != 0) && (crc != CRC_RESIDUE))
                   | (byte_cnt < MIN_LEN) | (byte_cnt > MAX_LEN)
                   | phase | rxer_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase          <= 1'b0;
      lo_nib         <= 4'd0;
      hold           <= 8'd0;
      hold_valid     <= 1'b0;
      first          <= 1'b0;
      crc            <= CRC_INIT;
      byte_cnt       <= 11'd0;
      rxer_seen      <= 1'b0;
      bus.out_data   <= 8'd0;
      bus.out_valid  <= 1'b0;
      bus.out_sof    <= 1'b0;
      bus.out_eof    <= 1'b0;
      bus.out_err    <= 1'b0;
      bus.good_count <= 16'd0;
      bus.bad_count  <= 16'd0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_err   <= 1'b0;

      if (start_data) begin
        phase      <= 1'b0;
        hold_valid <= 1'b0;
        first      <= 1'b1;
        crc        <= CRC_INIT;
        byte_cnt   <= 11'd0;
        rxer_seen  <= 1'b0;
      end

      if (state == DATA && rxdv_r) begin
        phase <= ~phase;
        if (!phase) lo_nib <= rxd_r;
        if (rxer_r) rxer_seen <= 1'b1;
      end

      // The previously held byte goes out when its successor completes.
      if (byte_done) begin
        crc        <= crc_byte(crc, new_byte);
        if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 11'd1;
        hold       <= new_byte;
        hold_valid <= 1'b1;
        if (hold_valid) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= hold;
          bus.out_sof   <= first;
          first         <= 1'b0;
        end
      end

      if (close_frame) begin
        hold_valid <= 1'b0;
        crc        <= CRC_INIT;
        if (hold_valid) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= hold;
          bus.out_sof   <= first;
          bus.out_eof   <= 1'b1;
          bus.out_err   <= frame_bad;
          first         <= 1'b0;
          if (frame_bad) bus.bad_count  <= bus.bad_count + 16'd1;
          else           bus.good_count <= bus.good_count + 16'd1;
        end else begin
          bus.bad_count <= bus.bad_count + 16'd1;
        end
      end

      if (drop_end) bus.bad_count <= bus.bad_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mii_rx_frame.sv
// Bench for mii_rx_frame: directed and random frames, expected bytes and counters
// queued at send time and checked by an independent output monitor.
module tb_mii_rx_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mii_rx_frame_if bif ();
  mii_rx_frame_if bif2 ();

  mii_rx_frame dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  mii_rx_frame #(.CHECK_CRC(0)) dut_nocrc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2)
  );

  int checks = 0;
  int failures = 0;
  // {data[42:35], sof[34], eof[33], err[32], good[31:16], bad[15:0]}
  logic [42:0] exp_q[$];
  logic [7:0]  frm[$];
  int exp_good = 0, exp_bad = 0, exp_good2 = 0, exp_bad2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented byte must match the head of the expected queue.
  always @(negedge clk) begin
    logic [42:0] e;
    if (rst_n && bif.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h expected=none at %0t", bif.out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {24'd0, bif.out_data}, {24'd0, e[42:35]});
        check("out_sof", {31'd0, bif.out_sof}, {31'd0, e[34]});
        check("out_eof", {31'd0, bif.out_eof}, {31'd0, e[33]});
        if (e[33]) begin
          check("out_err", {31'd0, bif.out_err}, {31'd0, e[32]});
          check("good_count_eof", {16'd0, bif.good_count}, {16'd0, e[31:16]});
          check("bad_count_eof", {16'd0, bif.bad_count}, {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk);
    #1;
    bif.mii_rxdv = dv;  bif.mii_rxd = d;  bif.mii_rxer = er;
    bif2.mii_rxdv = dv; bif2.mii_rxd = d; bif2.mii_rxer = er;
  endtask

  // Ethernet FCS of the first n bytes of frm (value sent LSB byte first).
  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ frm[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                  c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok();
    int n;
    n = frm.size();
    if (n < 4) return 1'b0;
    return eth_fcs(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
  endfunction

  task automatic build_frame(input int len);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom_range(0, 255)));
    if (len >= 4) begin
      f = eth_fcs(len - 4);
      frm.push_back(f[7:0]);
      frm.push_back(f[15:8]);
      frm.push_back(f[23:16]);
      frm.push_back(f[31:24]);
    end
  endtask

  task automatic check_idle_state();
    check("queue_drained", exp_q.size(), 0);
    check("good_count", {16'd0, bif.good_count}, 32'(exp_good & 16'hFFFF));
    check("bad_count", {16'd0, bif.bad_count}, 32'(exp_bad & 16'hFFFF));
    check("good_count_nocrc", {16'd0, bif2.good_count}, 32'(exp_good2 & 16'hFFFF));
    check("bad_count_nocrc", {16'd0, bif2.bad_count}, 32'(exp_bad2 & 16'hFFFF));
  endtask

  // Sends frm behind a 15x5+D preamble. extra: append a dribble nibble.
  // rxer_at: byte index carrying a PHY error (-1 none). rst_at: byte index at which
  // reset is pulsed for 5 byte times (-1 none).
  task automatic send_frame(input bit extra, input int rxer_at, input int rst_at, input int gap);
    int  n;
    bit  shape_bad, bad1, bad2;
    n = frm.size();
    shape_bad = (n < 64) || (n > 1518) || extra || (rxer_at >= 0 && rxer_at < n);
    bad1 = shape_bad || !fcs_ok();
    bad2 = shape_bad;
    if (rst_at < 0) begin
      if (n == 0 || bad1) exp_bad++;  else exp_good++;
      if (n == 0 || bad2) exp_bad2++; else exp_good2++;
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back({frm[i], i == 0, i == n - 1, bad1 && (i == n - 1),
                       16'(exp_good), 16'(exp_bad)});
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bif.out_valid}, 0);
        check("rst_out_data", {24'd0, bif.out_data}, 0);
        check("rst_good_count", {16'd0, bif.good_count}, 0);
        check("rst_bad_count", {16'd0, bif.bad_count}, 0);
        exp_q.delete();
        // the rest of this frame is seen after release and must be dropped
        exp_good = 0; exp_bad = 1; exp_good2 = 0; exp_bad2 = 1;
      end
      if (rst_at >= 0 && i == rst_at + 5) rst_n = 1'b1;
      drive(1'b1, frm[i][3:0], i == rxer_at);
      drive(1'b1, frm[i][7:4], 1'b0);
    end
    if (extra) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < gap; i++) drive(1'b0, 4'd0, 1'b0);
    if (gap >= 6) check_idle_state();
  endtask

  task automatic send_bad_preamble(input int n5, input logic [3:0] bad_nib, input int gap);
    exp_bad++;
    exp_bad2++;
    for (int i = 0; i < n5; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, bad_nib, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < gap; i++) drive(1'b0, 4'd0, 1'b0);
    if (gap >= 6) check_idle_state();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r, len;
    bif.mii_rxdv = 1'b0;  bif.mii_rxd = 4'd0;  bif.mii_rxer = 1'b0;
    bif2.mii_rxdv = 1'b0; bif2.mii_rxd = 4'd0; bif2.mii_rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, bif.out_valid}, 0);
    check("reset_out_sof", {31'd0, bif.out_sof}, 0);
    check("reset_out_eof", {31'd0, bif.out_eof}, 0);
    check("reset_out_err", {31'd0, bif.out_err}, 0);
    check("reset_out_data", {24'd0, bif.out_data}, 0);
    check("reset_good_count", {16'd0, bif.good_count}, 0);
    check("reset_bad_count", {16'd0, bif.bad_count}, 0);
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 4'd0, 1'b0);

    build_frame(64);   send_frame(1'b0, -1, -1, 8);          // clean frame
    build_frame(64);   frm[10] = frm[10] ^ 8'h04;            // FCS failure only
    send_frame(1'b0, -1, -1, 8);
    send_bad_preamble(2, 4'h3, 8);                           // 5,5,3
    send_bad_preamble(0, 4'h7, 8);                           // junk straight from idle
    build_frame(64);   send_frame(1'b0, 20, -1, 8);          // PHY error mid-frame
    build_frame(64);   send_frame(1'b1, -1, -1, 8);          // dribble nibble
    build_frame(63);   send_frame(1'b0, -1, -1, 8);          // runt
    build_frame(1519); send_frame(1'b0, -1, -1, 8);          // oversize
    build_frame(1518); send_frame(1'b0, -1, -1, 1);          // longest legal, tight gap
    build_frame(0);    send_frame(1'b0, -1, -1, 8);          // SFD then nothing
    build_frame(0);    send_frame(1'b1, -1, -1, 8);          // single nibble only
    build_frame(64);   send_frame(1'b0, -1, 30, 8);          // reset mid-frame
    build_frame(64);   send_frame(1'b0, -1, -1, 8);

    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(58, 130);
      build_frame(len);
      r = $urandom_range(0, 5);
      if (r == 0) begin
        r = $urandom_range(0, len - 1);
        frm[r] = frm[r] ^ (8'd1 << $urandom_range(0, 7));
        send_frame(1'b0, -1, -1, $urandom_range(1, 8));
      end else if (r == 1) begin
        send_frame(1'b1, -1, -1, $urandom_range(1, 8));
      end else if (r == 2) begin
        send_frame(1'b0, $urandom_range(0, len - 1), -1, $urandom_range(1, 8));
      end else begin
        send_frame(1'b0, -1, -1, $urandom_range(1, 8));
      end
    end

    repeat (8) drive(1'b0, 4'd0, 1'b0);
    check_idle_state();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
